p3_execute: RTL and testbench
=============================

Name: p3_execute

Overview:
- Execute stage of the SIMPLE multi-phase core; sits directly downstream of the p2 decode/register-read stage.
- Consumes p2's registered operands and control (alu1, alu2, opcode, writereg, memwrite, regaddress, address, storedata, isbranchout, condout, pcp2out, haltout).
- Performs the ALU operation and owns the SZCV condition-code register.
- Resolves branches and produces registered results for the memory/writeback phases (p4/p5).

Parameters:
- SQUASH_DEPTH, 0, number of instructions discarded after a taken branch (0 = multi-phase build, no squash).
- WIDTH, 16, datapath width.

Ports:
- clockp3  in  1  stage clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu1  in  16  operand A (Rs, or sign-extended immediate for LI).
- alu2  in  16  operand B (Rd); shift amount in alu2[3:0].
- opcode  in  4  arithmetic op (p2 forces 6 for LI).
- writereg  in  1  register-write request.
- memwrite  in  2  memory control passed through.
- regaddress  in  3  destination register.
- address  in  16  memory address, or branch displacement.
- storedata  in  16  store data.
- isbranch  in  1  instruction is B or Bcc.
- cond  in  3  branch condition.
- pcp2  in  16  PC of the following instruction.
- haltin  in  1  halt request.
- aluresult  out  16  registered ALU result.
- writeregout  out  1  registered write enable, gated by squash.
- memwriteout  out  2  registered, gated by squash.
- regaddressout  out  3  registered.
- addressout  out  16  registered.
- storedataout  out  16  registered.
- branchtaken  out  1  one-cycle pulse when a branch resolves taken.
- branchtarget  out  16  pcp2 + address, registered.
- flags  out  4  {S,Z,C,V}.
- haltout  out  1  sticky halt.

Behaviour:
- Reset: all outputs 0; flags 0; squash counter 0; haltout cleared. Reset wins over every other event in the same cycle.
- Latency: one posedge of clockp3, from inputs to all registered outputs.
- Opcode 0 ADD, A+B: C is the carry out of bit 15; V is signed overflow.
- Opcode 1 SUB and 5 CMP, B−A: C=1 when B<A unsigned (borrow); V is signed overflow. CMP keeps aluresult at its previous value.
- Opcodes 2 AND, 3 OR, 4 XOR (A op B) and 6 MOV/LI (result = A): C=V=0.
- Shifts act on B, with amount n = alu2[3:0]:
  - 8 SLL, logical left.
  - 9 SLR, rotate left.
  - 10 SRL, logical right.
  - 11 SRA, arithmetic right.
  - C = last bit shifted out; n=0 gives result B and C=0; V=0.
- S = result[15] and Z = (result == 0) for all ops above. Flags update only for opcodes 0–6 and 8–11, and only when writereg=1 or opcode=5.
- Opcodes 7, 12–15: aluresult and flags held.
- Branch condition (uses flags before this instruction's update):
  - cond 4: always taken.
  - cond 0: Z.
  - cond 1: S^V.
  - cond 2: Z|(S^V).
  - cond 3: !Z.
  - cond 5–7: not taken.
- Taken branch: branchtaken=1 for exactly one cycle; branchtarget = pcp2 + address, wrapping mod 2^16. Not-taken branch: branchtaken=0, target held.
- Squash counter: loaded with SQUASH_DEPTH on a taken branch, decremented each cycle while non-zero. While non-zero, writeregout=0, memwriteout=0, flags frozen, branches ignored, halt ignored.
- haltin=1 (not squashed) sets haltout; it stays set until reset. After halt, outputs and flags freeze.
- Simultaneous halt and taken branch: halt wins; branchtaken stays 0.

Optional Feature:
- Macro: SIMPLE_P3_IO_EN.
- With the macro:
  - Adds port inport (in, 16) and port outport (out, 16, reset 0).
  - Opcode 12 IN: aluresult = inport; S and Z update.
  - Opcode 13 OUT: outport <= A, registered and held until the next OUT.
- Without the macro: opcodes 12/13 behave as no-ops and no extra ports exist.

Decomposition:
- Package simple_pkg:
  - Opcode constants (OP_ADD…OP_HLT).
  - Condition constants (COND_BE=0, COND_BLT=1, COND_BLE=2, COND_BNE=3, COND_B=4).
  - Flag bit indices.
  - WIDTH default.
- One sub-module, simple_alu: combinational result plus {S,Z,C,V} from A, B and opcode. p3_execute owns all registers, branch resolution and the squash counter.

Test Plan:
- ADD 0x7FFF+0x0001 -> aluresult 0x8000, flags S=1 Z=0 C=0 V=1.
- CMP with B=3, A=5 -> aluresult unchanged, flags S=1 Z=0 C=1 V=0; a following BLT (cond 1) with pcp2=0x0010 and address=0xFFFC -> branchtaken pulses for one cycle, branchtarget=0x000C.
- SRA B=0x8001, n=1 -> 0xC000, C=1; SLR B=0x8001, n=1 -> 0x0003; n=0 -> result B, C=0.
- SQUASH_DEPTH=2, taken B, then two ADDs with writereg=1 -> writeregout=0 for both, flags frozen; the third ADD writes normally.
- haltin together with a taken branch -> haltout=1, branchtaken=0, outputs frozen; reset asserted mid-run -> all outputs and flags 0 on the next posedge.
- With SIMPLE_P3_IO_EN: OUT with A=0x1234 -> outport=0x1234; IN with inport=0 -> aluresult 0, Z=1.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared constants for the SIMPLE core: opcodes, branch conditions, flag layout.
// The optional I/O opcodes are enabled in p3_execute/simple_alu by SIMPLE_P3_IO_EN.
package simple_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [2:0] COND_BE  = 3'd0;
  localparam logic [2:0] COND_BLT = 3'd1;
  localparam logic [2:0] COND_BLE = 3'd2;
  localparam logic [2:0] COND_BNE = 3'd3;
  localparam logic [2:0] COND_B   = 3'd4;

  // Flags are packed {S,Z,C,V}
  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Branch condition evaluated against the current S, Z, V flags
  function automatic logic cond_met(input logic s, input logic z, input logic v,
                                    input logic [2:0] c);
    logic lt;
    lt = s ^ v;
    case (c)
      COND_BE:  cond_met = z;
      COND_BLT: cond_met = lt;
      COND_BLE: cond_met = z | lt;
      COND_BNE: cond_met = ~z;
      COND_B:   cond_met = 1'b1;
      default:  cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/simple_alu.sv
// Combinational ALU for the p3 execute stage: result plus {S,Z,C,V}.
// SIMPLE_P3_IO_EN adds the IN opcode (result taken from i_inport).
module simple_alu
  import simple_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
`ifdef SIMPLE_P3_IO_EN
  input  logic [WIDTH-1:0] i_inport,
`endif
  output logic [WIDTH-1:0] o_result_c,
  output logic [3:0]       o_flags_c,
  output logic             o_upd_c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]   w_n;
  logic [SH_W:0]     w_rn;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_dif;
  logic [WIDTH:0]    w_sl;
  logic [WIDTH-1:0]  w_rl;
  logic [WIDTH:0]    w_sr;
  logic signed [WIDTH:0] w_sa;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic              w_v;

  // Shifts keep one guard bit so the last bit shifted out lands in a fixed position
  always_comb begin
    w_n   = i_b[SH_W-1:0];
    w_rn  = (SH_W+1)'(WIDTH) - {1'b0, w_n};
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    w_dif = {1'b0, i_b} - {1'b0, i_a};
    w_sl  = {1'b0, i_b} << w_n;
    w_rl  = (i_b << w_n) | (i_b >> w_rn);
    w_sr  = {i_b, 1'b0} >> w_n;
    w_sa  = $signed({i_b, 1'b0}) >>> w_n;
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    o_upd_c = 1'b1;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_b[WIDTH-1]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_MOV: w_res = i_a;
      OP_SLL: begin
        w_res = w_sl[WIDTH-1:0];
        w_c   = w_sl[WIDTH];
      end
      OP_SLR: begin
        w_res = w_rl;
        w_c   = (w_n != '0) & w_rl[0];
      end
      OP_SRL: begin
        w_res = w_sr[WIDTH:1];
        w_c   = w_sr[0];
      end
      OP_SRA: begin
        w_res = w_sa[WIDTH:1];
        w_c   = w_sa[0];
      end
`ifdef SIMPLE_P3_IO_EN
      OP_IN:  w_res = i_inport;
`endif
      default: o_upd_c = 1'b0;
    endcase
    o_result_c = w_res;
    o_flags_c  = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

endmodule

// File: rtl/p3_execute.sv
// SIMPLE core execute stage: ALU, SZCV flags, branch resolution, squash and halt.
// SIMPLE_P3_IO_EN adds inport/outport and the IN/OUT opcodes.
module p3_execute
  import simple_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 0,
  parameter int unsigned WIDTH        = WIDTH_DEF
) (
  input  logic             clockp3,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu1,
  input  logic [WIDTH-1:0] alu2,
  input  logic [3:0]       opcode,
  input  logic             writereg,
  input  logic [1:0]       memwrite,
  input  logic [2:0]       regaddress,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] storedata,
  input  logic             isbranch,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] pcp2,
  input  logic             haltin,
`ifdef SIMPLE_P3_IO_EN
  input  logic [WIDTH-1:0] inport,
  output logic [WIDTH-1:0] outport,
`endif
  output logic [WIDTH-1:0] aluresult,
  output logic             writeregout,
  output logic [1:0]       memwriteout,
  output logic [2:0]       regaddressout,
  output logic [WIDTH-1:0] addressout,
  output logic [WIDTH-1:0] storedataout,
  output logic             branchtaken,
  output logic [WIDTH-1:0] branchtarget,
  output logic [3:0]       flags,
  output logic             haltout
);

  localparam int unsigned SQ_W = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

  logic [WIDTH-1:0] r_aluresult, r_addressout, r_storedataout, r_branchtarget;
  logic             r_writeregout, r_branchtaken, r_haltout;
  logic [1:0]       r_memwriteout;
  logic [2:0]       r_regaddressout;
  logic [3:0]       r_flags;
  logic [SQ_W-1:0]  r_squash;

  logic [WIDTH-1:0] w_alu_res;
  logic [3:0]       w_alu_flags, w_flags_nxt;
  logic             w_alu_upd, w_live, w_halt_now, w_adv, w_commit, w_take, w_flag_we;

  simple_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a        (alu1),
    .i_b        (alu2),
    .i_op       (opcode),
`ifdef SIMPLE_P3_IO_EN
    .i_inport   (inport),
`endif
    .o_result_c (w_alu_res),
    .o_flags_c  (w_alu_flags),
    .o_upd_c    (w_alu_upd)
  );

  // live: instruction may act; adv: stage registers move; commit: side effects allowed
  assign w_live     = !r_haltout && (r_squash == '0);
  assign w_halt_now = w_live && haltin;
  assign w_adv      = !r_haltout && !w_halt_now;
  assign w_commit   = w_live && !haltin;
  assign w_take     = w_commit && isbranch &&
                      cond_met(r_flags[FLAG_S], r_flags[FLAG_Z], r_flags[FLAG_V], cond);
  assign w_flag_we  = w_commit && w_alu_upd && (writereg || (opcode == OP_CMP));

`ifdef SIMPLE_P3_IO_EN
  // IN only defines S and Z; C and V carry over
  assign w_flags_nxt = (opcode == OP_IN) ? {w_alu_flags[3:2], r_flags[1:0]} : w_alu_flags;
`else
  assign w_flags_nxt = w_alu_flags;
`endif

  always_ff @(posedge clockp3) begin
    if (reset) begin
      r_aluresult     <= '0;
      r_writeregout   <= 1'b0;
      r_memwriteout   <= '0;
      r_regaddressout <= '0;
      r_addressout    <= '0;
      r_storedataout  <= '0;
      r_branchtaken   <= 1'b0;
      r_branchtarget  <= '0;
      r_flags         <= '0;
      r_haltout       <= 1'b0;
      r_squash        <= '0;
    end else begin
      r_branchtaken <= w_take;
      if (w_take) begin
        r_branchtarget <= pcp2 + address;
        r_squash       <= SQ_W'(SQUASH_DEPTH);
      end else if (r_squash != '0) begin
        r_squash <= r_squash - SQ_W'(1);
      end
      if (w_halt_now) r_haltout <= 1'b1;
      if (w_adv) begin
        r_writeregout   <= w_commit & writereg;
        r_memwriteout   <= w_commit ? memwrite : 2'b00;
        r_regaddressout <= regaddress;
        r_addressout    <= address;
        r_storedataout  <= storedata;
        if (w_alu_upd && (opcode != OP_CMP)) r_aluresult <= w_alu_res;
      end
      if (w_flag_we) r_flags <= w_flags_nxt;
    end
  end

`ifdef SIMPLE_P3_IO_EN
  logic [WIDTH-1:0] r_outport;

  always_ff @(posedge clockp3) begin
    if (reset)                              r_outport <= '0;
    else if (w_commit && opcode == OP_OUT)  r_outport <= alu1;
  end

  assign outport = r_outport;
`endif

  assign aluresult     = r_aluresult;
  assign writeregout   = r_writeregout;
  assign memwriteout   = r_memwriteout;
  assign regaddressout = r_regaddressout;
  assign addressout    = r_addressout;
  assign storedataout  = r_storedataout;
  assign branchtaken   = r_branchtaken;
  assign branchtarget  = r_branchtarget;
  assign flags         = r_flags;
  assign haltout       = r_haltout;

endmodule

// File: tb/tb_p3_execute.sv
// Bench for p3_execute: default build (no squash) plus a SQUASH_DEPTH=2 copy.
// IN/OUT checks are compiled in when SIMPLE_P3_IO_EN is defined.
module tb_p3_execute;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, writereg, isbranch, haltin;
  logic [15:0] alu1, alu2, address, storedata, pcp2;
  logic [3:0]  opcode;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress, cond;

  logic [15:0] a_res, a_ad, a_sd, a_tgt, q_res, q_ad, q_sd, q_tgt;
  logic        a_wr, a_bt, a_halt, q_wr, q_bt, q_halt;
  logic [1:0]  a_mw, q_mw;
  logic [2:0]  a_ra, q_ra;
  logic [3:0]  a_fl, q_fl;
`ifdef SIMPLE_P3_IO_EN
  logic [15:0] inport, a_outp, q_outp;
`endif

  p3_execute dut (
    .clockp3(clk), .reset(reset), .alu1(alu1), .alu2(alu2), .opcode(opcode),
    .writereg(writereg), .memwrite(memwrite), .regaddress(regaddress), .address(address),
    .storedata(storedata), .isbranch(isbranch), .cond(cond), .pcp2(pcp2), .haltin(haltin),
`ifdef SIMPLE_P3_IO_EN
    .inport(inport), .outport(a_outp),
`endif
    .aluresult(a_res), .writeregout(a_wr), .memwriteout(a_mw), .regaddressout(a_ra),
    .addressout(a_ad), .storedataout(a_sd), .branchtaken(a_bt), .branchtarget(a_tgt),
    .flags(a_fl), .haltout(a_halt)
  );

  p3_execute #(.SQUASH_DEPTH(2)) dut_sq (
    .clockp3(clk), .reset(reset), .alu1(alu1), .alu2(alu2), .opcode(opcode),
    .writereg(writereg), .memwrite(memwrite), .regaddress(regaddress), .address(address),
    .storedata(storedata), .isbranch(isbranch), .cond(cond), .pcp2(pcp2), .haltin(haltin),
`ifdef SIMPLE_P3_IO_EN
    .inport(inport), .outport(q_outp),
`endif
    .aluresult(q_res), .writeregout(q_wr), .memwriteout(q_mw), .regaddressout(q_ra),
    .addressout(q_ad), .storedataout(q_sd), .branchtaken(q_bt), .branchtarget(q_tgt),
    .flags(q_fl), .haltout(q_halt)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        wr, br;
    logic [2:0]  cnd;
    logic [15:0] pc, ad;
    logic [15:0] e_res;
    logic [3:0]  e_fl;
    logic        e_bt;
    logic [15:0] e_tgt;
  } vec_t;

  typedef struct {
    logic [15:0] res, tgt, ad, sd;
    logic [3:0]  fl;
    logic        bt, wr;
    logic [1:0]  mw;
    logic [2:0]  ra;
  } exp_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic wr, input logic br, input logic [2:0] cnd,
                              input logic [15:0] pc, input logic [15:0] ad,
                              input logic [15:0] e_res, input logic [3:0] e_fl,
                              input logic e_bt, input logic [15:0] e_tgt);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wr = wr; v.br = br; v.cnd = cnd; v.pc = pc; v.ad = ad;
    v.e_res = e_res; v.e_fl = e_fl; v.e_bt = e_bt; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic wr, input logic br, input logic [2:0] cnd,
                       input logic [15:0] pc, input logic [15:0] ad, input logic hlt);
    opcode = op; alu1 = a; alu2 = b; writereg = wr; isbranch = br; cond = cnd;
    pcp2 = pc; address = ad; haltin = hlt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Expected values below follow the running flag state {S,Z,C,V} from reset
    tbl[0]  = mk(4'd0,  16'h7FFF, 16'h0001, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h8000, 4'b1001, 0, 16'h0000);
    tbl[1]  = mk(4'd5,  16'h0005, 16'h0003, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h8000, 4'b1010, 0, 16'h0000);
    tbl[2]  = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd1, 16'h0010, 16'hFFFC, 16'h8000, 4'b1010, 1, 16'h000C);
    tbl[3]  = mk(4'd7,  16'h0000, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h8000, 4'b1010, 0, 16'h000C);
    tbl[4]  = mk(4'd11, 16'h0000, 16'h8001, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'hC000, 4'b1010, 0, 16'h000C);
    tbl[5]  = mk(4'd9,  16'h0000, 16'h8001, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0003, 4'b0010, 0, 16'h000C);
    tbl[6]  = mk(4'd8,  16'h0000, 16'h8000, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h8000, 4'b1000, 0, 16'h000C);
    tbl[7]  = mk(4'd10, 16'h0000, 16'h0FFC, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0110, 0, 16'h000C);
    tbl[8]  = mk(4'd1,  16'h0001, 16'h8000, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h7FFF, 4'b0001, 0, 16'h000C);
    tbl[9]  = mk(4'd2,  16'hF0F0, 16'hFF00, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'hF000, 4'b1000, 0, 16'h000C);
    tbl[10] = mk(4'd3,  16'h00F0, 16'h0F00, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0FF0, 4'b1000, 0, 16'h000C);
    tbl[11] = mk(4'd4,  16'h1234, 16'h1234, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 0, 16'h000C);
    tbl[12] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd0, 16'h0100, 16'h0020, 16'h0000, 4'b0100, 1, 16'h0120);
    tbl[13] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd3, 16'h0200, 16'h0002, 16'h0000, 4'b0100, 0, 16'h0120);
    tbl[14] = mk(4'd0,  16'hFFFF, 16'h0001, 1, 1, 3'd2, 16'hFFF0, 16'h0020, 16'h0000, 4'b0110, 1, 16'h0010);
    tbl[15] = mk(4'd6,  16'hABCD, 16'h0000, 1, 1, 3'd5, 16'h1111, 16'h1111, 16'hABCD, 4'b1000, 0, 16'h0010);
    tbl[16] = mk(4'd14, 16'h0001, 16'h0001, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'hABCD, 4'b1000, 0, 16'h0010);
    tbl[17] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd4, 16'h8000, 16'h8000, 16'hABCD, 4'b1000, 1, 16'h0000);
    tbl[18] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd2, 16'h0004, 16'h0006, 16'hABCD, 4'b1000, 1, 16'h000A);
    tbl[19] = mk(4'd7,  16'h0000, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'hABCD, 4'b1000, 0, 16'h000A);
    tbl[20] = mk(4'd5,  16'h0008, 16'h0008, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'hABCD, 4'b0100, 0, 16'h000A);
    tbl[21] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd3, 16'h0300, 16'h0001, 16'hABCD, 4'b0100, 0, 16'h000A);
    tbl[22] = mk(4'd7,  16'h0000, 16'h0000, 0, 1, 3'd1, 16'h0000, 16'h0005, 16'hABCD, 4'b0100, 0, 16'h000A);
    tbl[23] = mk(4'd15, 16'h0005, 16'h0005, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'hABCD, 4'b0100, 0, 16'h000A);
    tbl[24] = mk(4'd0,  16'h8000, 16'h8000, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0111, 0, 16'h000A);

    reset = 1'b1; memwrite = 2'd0; regaddress = 3'd0; storedata = 16'h0;
`ifdef SIMPLE_P3_IO_EN
    inport = 16'h0;
`endif
    drive(4'd0, 16'h0, 16'h0, 0, 0, 3'd0, 16'h0, 16'h0, 0);
    step(); step();

    // Reset state
    chk("rst.res", 32'(a_res), 32'h0);
    chk("rst.flags", 32'(a_fl), 32'h0);
    chk("rst.wr", 32'(a_wr), 32'h0);
    chk("rst.bt", 32'(a_bt), 32'h0);
    chk("rst.tgt", 32'(a_tgt), 32'h0);
    chk("rst.halt", 32'(a_halt), 32'h0);
    chk("rst.mw", 32'(a_mw), 32'h0);
`ifdef SIMPLE_P3_IO_EN
    chk("rst.outport", 32'(a_outp), 32'h0);
`endif
    reset = 1'b0;

    // Table: drive, push expectation, pop after the edge
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wr, tbl[i].br, tbl[i].cnd, tbl[i].pc, tbl[i].ad, 0);
      memwrite = 2'(i); regaddress = 3'(i); storedata = 16'(i) * 16'h0101;
      e.res = tbl[i].e_res; e.fl = tbl[i].e_fl; e.bt = tbl[i].e_bt; e.tgt = tbl[i].e_tgt;
      e.wr = tbl[i].wr; e.mw = memwrite; e.ra = regaddress; e.ad = tbl[i].ad; e.sd = storedata;
      sb_q.push_back(e);
      step();
      e = sb_q.pop_front();
      chk($sformatf("v%0d.res", i), 32'(a_res), 32'(e.res));
      chk($sformatf("v%0d.flags", i), 32'(a_fl), 32'(e.fl));
      chk($sformatf("v%0d.bt", i), 32'(a_bt), 32'(e.bt));
      chk($sformatf("v%0d.tgt", i), 32'(a_tgt), 32'(e.tgt));
      chk($sformatf("v%0d.wr", i), 32'(a_wr), 32'(e.wr));
      chk($sformatf("v%0d.pass", i), {a_mw, a_ra, a_ad, a_sd[10:0]}, {e.mw, e.ra, e.ad, e.sd[10:0]});
      chk($sformatf("v%0d.sd", i), 32'(a_sd), 32'(e.sd));
    end

    // Squash: taken B, two squashed ADDs (with ignored halt and branch), then a live ADD
    reset = 1'b1; drive(4'd7, 16'h0, 16'h0, 0, 0, 3'd0, 16'h0, 16'h0, 0); step(); reset = 1'b0;
    memwrite = 2'd2; regaddress = 3'd1;
    drive(4'd7, 16'h0, 16'h0, 0, 1, 3'd4, 16'h0040, 16'h0010, 0); step();
    chk("sq.b.bt", 32'(q_bt), 32'h1);
    chk("sq.b.tgt", 32'(q_tgt), 32'h0050);
    drive(4'd0, 16'h0001, 16'h0001, 1, 0, 3'd0, 16'h0, 16'h0, 1); step();
    chk("sq.add1.wr", 32'(q_wr), 32'h0);
    chk("sq.add1.mw", 32'(q_mw), 32'h0);
    chk("sq.add1.flags", 32'(q_fl), 32'h0);
    chk("sq.add1.halt", 32'(q_halt), 32'h0);
    drive(4'd0, 16'hFFFF, 16'h0001, 1, 1, 3'd4, 16'h0000, 16'h0100, 0); step();
    chk("sq.add2.wr", 32'(q_wr), 32'h0);
    chk("sq.add2.flags", 32'(q_fl), 32'h0);
    chk("sq.add2.bt", 32'(q_bt), 32'h0);
    chk("sq.add2.tgt", 32'(q_tgt), 32'h0050);
    drive(4'd0, 16'h7FFF, 16'h0001, 1, 0, 3'd0, 16'h0, 16'h0, 0); step();
    chk("sq.add3.wr", 32'(q_wr), 32'h1);
    chk("sq.add3.mw", 32'(q_mw), 32'h2);
    chk("sq.add3.flags", 32'(q_fl), 32'b1001);
    chk("sq.add3.res", 32'(q_res), 32'h8000);

    // Halt together with a taken branch, freeze, then reset mid-run
    reset = 1'b1; step(); reset = 1'b0;
    regaddress = 3'd5; memwrite = 2'd0;
    drive(4'd0, 16'h0002, 16'h0003, 1, 0, 3'd0, 16'h0, 16'h0, 0); step();
    chk("h.add.res", 32'(a_res), 32'h0005);
    regaddress = 3'd2;
    drive(4'd0, 16'h0001, 16'h0001, 1, 1, 3'd4, 16'h0100, 16'h0001, 1); step();
    chk("h.halt", 32'(a_halt), 32'h1);
    chk("h.bt", 32'(a_bt), 32'h0);
    chk("h.tgt", 32'(a_tgt), 32'h0);
    chk("h.res", 32'(a_res), 32'h0005);
    chk("h.ra", 32'(a_ra), 32'h5);
    drive(4'd0, 16'h7FFF, 16'h0001, 1, 1, 3'd4, 16'h0100, 16'h0001, 0); step();
    chk("h2.res", 32'(a_res), 32'h0005);
    chk("h2.flags", 32'(a_fl), 32'h0);
    chk("h2.halt", 32'(a_halt), 32'h1);
    chk("h2.bt", 32'(a_bt), 32'h0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rr.res", 32'(a_res), 32'h0);
    chk("rr.flags", 32'(a_fl), 32'h0);
    chk("rr.halt", 32'(a_halt), 32'h0);
    chk("rr.bt", 32'(a_bt), 32'h0);
    chk("rr.wr", 32'(a_wr), 32'h0);
    chk("rr.tgt", 32'(a_tgt), 32'h0);

`ifdef SIMPLE_P3_IO_EN
    // OUT then IN
    drive(4'd13, 16'h1234, 16'h0, 0, 0, 3'd0, 16'h0, 16'h0, 0); step();
    chk("io.out", 32'(a_outp), 32'h1234);
    chk("io.out.res", 32'(a_res), 32'h0);
    inport = 16'h0;
    drive(4'd12, 16'h0, 16'h0, 1, 0, 3'd0, 16'h0, 16'h0, 0); step();
    chk("io.in0.res", 32'(a_res), 32'h0);
    chk("io.in0.flags", 32'(a_fl), 32'b0100);
    inport = 16'h8000;
    drive(4'd12, 16'h0, 16'h0, 1, 0, 3'd0, 16'h0, 16'h0, 0); step();
    chk("io.in1.res", 32'(a_res), 32'h8000);
    chk("io.in1.flags", 32'(a_fl), 32'b1000);
    chk("io.out.held", 32'(a_outp), 32'h1234);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
